range_match_array: RTL and testbench
====================================

# range_match_array

Parametrised systolic range-membership engine for the day-5 ingredient-ID datapath. It loads up to DEPTH inclusive ranges into a shift chain of comparator slots and streams IDs through under a valid/ready handshake. Each ID emerges DEPTH cycles later with a hit flag and a last marker, and the block keeps a saturating hit count. It replaces the fixed, unqualified range chain: unloaded slots never match, loads are gated against in-flight IDs, and overflow and end-of-stream are reported.

## Interface
- WIDTH, 64, bit width of range bounds and IDs
- DEPTH, 183, number of range slots (≥2); also the pipeline latency
- CNT_W, 32, width of the hit counter
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- load_valid  in  1  range write request
- load_ready  out  1  high when no ID is in flight
- start_range, end_range  in  WIDTH  inclusive bounds, unsigned
- id_valid  in  1  ID offered
- id_ready  out  1  equal to ~load_valid
- id  in  WIDTH  ID value
- id_last  in  1  marks the final ID of a batch
- count_clear  in  1  synchronous clear of total_fresh
- out_valid, out_hit, out_last  out  1  result strobe, membership result, last marker
- out_id  out  WIDTH  ID echoed with its result
- out_idx  out  $clog2(DEPTH)  first matching slot (only with the macro)
- total_fresh  out  CNT_W  saturating count of hits
- loaded  out  $clog2(DEPTH+1)  number of valid slots, saturating at DEPTH
- overflow  out  1  sticky; a range was pushed out of slot DEPTH-1
- done  out  1  one-cycle pulse when an out_last result is produced

## Operation
- Load accept: load_valid && load_ready.
  - On accept, the new range and a slot-valid bit enter slot 0, and every slot k shifts into k+1.
  - The content of slot DEPTH-1 is discarded. If that slot was valid, overflow is set.
- ID accept: id_valid && id_ready.
  - The {id, valid, last, hit=0} token enters stage 0.
  - A bubble enters when no ID is accepted. The pipeline never stalls, because there is no output backpressure.
- Stage k: hit_out = hit_in | (slot_valid[k] && start[k] ≤ id && id ≤ end[k]).
  - Comparisons are unsigned.
  - A range with start > end never matches.
  - An empty slot never matches, including for id 0.
- Result stage: total_fresh increments on out_valid && out_hit, saturating at all-ones.
  - count_clear takes priority, so a clear coinciding with an increment yields 0.
- An inflight counter tracks accepted IDs not yet output.
  - load_ready = (inflight == 0) && !id_accepted_this_cycle.
  - This keeps slot contents stable during every comparison.
- loaded increments on each load accept and saturates at DEPTH.
- No state machine beyond the counters. Batch framing comes from id_last and done only.

## Timing
- Reset values:
  - All slots invalid and zeroed.
  - out_valid, out_hit, out_last, done, overflow = 0.
  - out_id, out_idx, total_fresh, loaded = 0.
  - load_ready = 1.
- Latency: an ID accepted in cycle t produces out_valid in cycle t+DEPTH. Throughput is one ID per cycle.
- done asserts in the same cycle as out_valid && out_last.
- total_fresh reflects a hit one cycle after the corresponding out_valid.
- A range loaded in cycle t is visible to IDs accepted from t+1 onward.
- Reset mid-stream drops all in-flight tokens, and no out_valid follows.

## Configuration
- RANGE_MATCH_INDEX_EN defined: each token carries the index of the first slot that matched.
  - The index is captured only when the incoming hit is 0.
  - out_idx is valid when out_valid && out_hit, and is 0 otherwise.
  - Slot 0 holds the most recently loaded range.
- Macro undefined: the out_idx port and the index pipeline are absent.

## Structure
- Package range_match_pkg holds:
  - typedef range_t {start, end}
  - typedef token_t {id, valid, last, hit[, idx]}
  - parameter defaults
- One sub-module, range_match_pe: one slot register, its slot-valid bit and one token stage. The top is a generate chain of range_match_pe plus the counters.

## Test plan
- No loads, stream id 0 then id 5 (last) -> out_hit 0, 0; total_fresh 0; done pulses once.
- Load 3-5, 10-14, 16-20, 12-18, then stream 1, 5, 8, 11, 17, 32 (last) -> hits 0,1,0,1,1,0; total_fresh 3; out_valid exactly DEPTH cycles after each accept.
- DEPTH=4, load 5 ranges -> overflow 1, loaded 4; the first range is evicted and no longer matches.
- Assert load_valid one cycle after an ID accept -> load_ready low for DEPTH cycles; the load lands after drain; the in-flight ID's result is unaffected.
- CNT_W=2, stream 5 hitting IDs -> total_fresh 3 (saturated); count_clear with a simultaneous hit -> 0.
- With RANGE_MATCH_INDEX_EN and the ranges of scenario 2, stream 17, 11, 5 -> out_idx 0, 2, 3.

Source files
------------

// File: rtl/range_match_pkg.sv
// Shared types and defaults for the systolic range-membership engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Structs are sized for the widest supported ID/bound (RM_WIDTH bits) and
// slot index (RM_IDX_W bits). Narrower instances zero-extend into them.
// Optional feature macro: RANGE_MATCH_INDEX_EN adds a first-match slot
// index to each token.
package range_match_pkg;

  localparam int unsigned RM_WIDTH = 64;   // widest ID / bound carried in structs
  localparam int unsigned RM_DEPTH = 183;  // default number of range slots
  localparam int unsigned RM_CNT_W = 32;   // default hit counter width
  localparam int unsigned RM_IDX_W = 8;    // slot index width, covers DEPTH <= 256

  // Inclusive range held by one comparator slot.
  typedef struct packed {
    logic [RM_WIDTH-1:0] range_start;
    logic [RM_WIDTH-1:0] range_end;
  } range_t;

  // Token travelling down the comparator chain, one stage per cycle.
  typedef struct packed {
    logic [RM_WIDTH-1:0] id;
    logic                valid;
    logic                last;
    logic                hit;
`ifdef RANGE_MATCH_INDEX_EN
    logic [RM_IDX_W-1:0] idx;
`endif
  } token_t;

  // Unsigned inclusive membership; start > end can never satisfy both sides.
  function automatic logic in_range(input range_t r, input logic [RM_WIDTH-1:0] v);
    return (r.range_start <= v) && (v <= r.range_end);
  endfunction

endpackage

// File: rtl/range_match_pe.sv
// One comparator slot of the range chain: range register, slot-valid bit, one token stage.
// Latency: 1 cycle from token_in to token_out.
// Backpressure: none; the token stage advances every cycle, the slot shifts only on load_en.
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   load_en                 shift range_in/slot_valid_in into this slot
//   range_in, slot_valid_in range and valid bit from the previous slot (or the load port)
//   token_in, token_out     token entering / leaving this stage
//   range_out, slot_valid_out  this slot's contents, feeding the next slot
//   slot_idx                constant index of this slot (RANGE_MATCH_INDEX_EN only)
module range_match_pe
  import range_match_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                load_en,
  input  range_t              range_in,
  input  logic                slot_valid_in,
  input  token_t              token_in,
`ifdef RANGE_MATCH_INDEX_EN
  input  logic [RM_IDX_W-1:0] slot_idx,
`endif
  output range_t              range_out,
  output logic                slot_valid_out,
  output token_t              token_out
);

  range_t rng_q;
  logic   slot_vld_q;
  token_t tok_q;
  token_t tok_nxt;
  logic   match;

  // Bubbles and empty slots never produce a hit, so id 0 cannot match an
  // all-zero unloaded slot.
  assign match = slot_vld_q && token_in.valid && in_range(rng_q, token_in.id);

  always_comb begin
    tok_nxt     = token_in;
    tok_nxt.hit = token_in.hit | match;
`ifdef RANGE_MATCH_INDEX_EN
    // Only the first (lowest-numbered) matching slot records its index.
    if (match && !token_in.hit) begin
      tok_nxt.idx = slot_idx;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rng_q      <= '0;
      slot_vld_q <= 1'b0;
      tok_q      <= '0;
    end else begin
      if (load_en) begin
        rng_q      <= range_in;
        slot_vld_q <= slot_valid_in;
      end
      tok_q <= tok_nxt;
    end
  end

  assign range_out      = rng_q;
  assign slot_valid_out = slot_vld_q;
  assign token_out      = tok_q;

endmodule

// File: rtl/range_match_array.sv
// Systolic range-membership engine: DEPTH range slots, IDs streamed through for hit/last results.
// Latency: an ID accepted in cycle t appears on out_* in cycle t+DEPTH; one ID per cycle.
// Backpressure: none on the output; loads wait until no ID is in flight, IDs wait while a load is offered.
// Ports:
//   clock, reset                   clock and synchronous active-high reset
//   load_valid/load_ready          range write handshake; start_range/end_range inclusive bounds
//   id_valid/id_ready, id, id_last ID stream handshake and batch-end marker
//   count_clear                    clears total_fresh (wins over an increment)
//   out_valid/out_hit/out_last/out_id  result stream
//   out_idx                        first matching slot (RANGE_MATCH_INDEX_EN only)
//   total_fresh                    saturating hit count
//   loaded, overflow, done         occupied slots, sticky eviction flag, end-of-batch pulse
// Optional feature macro: RANGE_MATCH_INDEX_EN. WIDTH <= 64 and DEPTH <= 256 are supported.
module range_match_array
  import range_match_pkg::*;
#(
  parameter int unsigned WIDTH = RM_WIDTH,
  parameter int unsigned DEPTH = RM_DEPTH,
  parameter int unsigned CNT_W = RM_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [WIDTH-1:0]           start_range,
  input  logic [WIDTH-1:0]           end_range,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic [WIDTH-1:0]           id,
  input  logic                       id_last,
  input  logic                       count_clear,
  output logic                       out_valid,
  output logic                       out_hit,
  output logic                       out_last,
  output logic [WIDTH-1:0]           out_id,
`ifdef RANGE_MATCH_INDEX_EN
  output logic [$clog2(DEPTH)-1:0]   out_idx,
`endif
  output logic [CNT_W-1:0]           total_fresh,
  output logic [$clog2(DEPTH+1)-1:0] loaded,
  output logic                       overflow,
  output logic                       done
);

  localparam int unsigned LOAD_W = $clog2(DEPTH+1);

  logic   id_acc;
  logic   load_acc;
  range_t new_range;
  token_t tok_in;
  token_t tail;

  range_t rng_q      [DEPTH];
  logic   slot_vld_q [DEPTH];
  token_t tok_q      [DEPTH];

  logic [LOAD_W-1:0] inflight_q;
  logic [LOAD_W-1:0] loaded_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  count_q;

  // Handshakes. A load is only taken with the chain empty and no ID entering
  // in the same cycle, so slot contents never change under a live comparison.
  assign id_ready   = ~load_valid;
  assign id_acc     = id_valid & id_ready;
  assign load_ready = (inflight_q == '0) & ~id_acc;
  assign load_acc   = load_valid & load_ready;

  assign new_range.range_start = RM_WIDTH'(start_range);
  assign new_range.range_end   = RM_WIDTH'(end_range);

  // Bubbles are all-zero tokens.
  always_comb begin
    tok_in = '0;
    if (id_acc) begin
      tok_in.id    = RM_WIDTH'(id);
      tok_in.valid = 1'b1;
      tok_in.last  = id_last;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    range_t r_in;
    logic   v_in;
    token_t t_in;

    if (k == 0) begin : g_head
      assign r_in = new_range;
      assign v_in = 1'b1;
      assign t_in = tok_in;
    end else begin : g_body
      assign r_in = rng_q[k-1];
      assign v_in = slot_vld_q[k-1];
      assign t_in = tok_q[k-1];
    end

    range_match_pe u_pe (
      .clock          (clock),
      .reset          (reset),
      .load_en        (load_acc),
      .range_in       (r_in),
      .slot_valid_in  (v_in),
      .token_in       (t_in),
`ifdef RANGE_MATCH_INDEX_EN
      .slot_idx       (RM_IDX_W'(k)),
`endif
      .range_out      (rng_q[k]),
      .slot_valid_out (slot_vld_q[k]),
      .token_out      (tok_q[k])
    );
  end

  assign tail      = tok_q[DEPTH-1];
  assign out_valid = tail.valid;
  assign out_hit   = tail.valid & tail.hit;
  assign out_last  = tail.valid & tail.last;
  assign out_id    = tail.id[WIDTH-1:0];
  assign done      = out_valid & out_last;
`ifdef RANGE_MATCH_INDEX_EN
  assign out_idx   = out_hit ? tail.idx[$clog2(DEPTH)-1:0] : '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
      loaded_q   <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      // Accepted-but-not-yet-output IDs; the output cycle still counts.
      if (id_acc && !out_valid) begin
        inflight_q <= inflight_q + LOAD_W'(1);
      end else if (!id_acc && out_valid) begin
        inflight_q <= inflight_q - LOAD_W'(1);
      end

      if (load_acc && (loaded_q != LOAD_W'(DEPTH))) begin
        loaded_q <= loaded_q + LOAD_W'(1);
      end

      // A valid range falling off the end of the chain is lost for good.
      if (load_acc && slot_vld_q[DEPTH-1]) begin
        overflow_q <= 1'b1;
      end

      if (count_clear) begin
        count_q <= '0;
      end else if (out_hit && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign loaded      = loaded_q;
  assign overflow    = overflow_q;
  assign total_fresh = count_q;

endmodule

// File: tb/tb_range_match_array.sv
module tb_range_match_array;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic                       load_valid = 1'b0;
  logic                       load_ready;
  logic [WIDTH-1:0]           start_range = '0;
  logic [WIDTH-1:0]           end_range = '0;
  logic                       id_valid = 1'b0;
  logic                       id_ready;
  logic [WIDTH-1:0]           id = '0;
  logic                       id_last = 1'b0;
  logic                       count_clear = 1'b0;
  logic                       out_valid, out_hit, out_last, overflow, done;
  logic [WIDTH-1:0]           out_id;
`ifdef RANGE_MATCH_INDEX_EN
  logic [$clog2(DEPTH)-1:0]   out_idx;
`endif
  logic [CNT_W-1:0]           total_fresh;
  logic [$clog2(DEPTH+1)-1:0] loaded;

  range_match_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .start_range (start_range),
    .end_range   (end_range),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id          (id),
    .id_last     (id_last),
    .count_clear (count_clear),
    .out_valid   (out_valid),
    .out_hit     (out_hit),
    .out_last    (out_last),
    .out_id      (out_id),
`ifdef RANGE_MATCH_INDEX_EN
    .out_idx     (out_idx),
`endif
    .total_fresh (total_fresh),
    .loaded      (loaded),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Reference model: list of loaded ranges (most recent first), expected results by due cycle.
  typedef struct { int s; int e; } rng_t;
  typedef struct { int due; int id; bit hit; bit last; int idx; } exp_t;

  rng_t ranges[$];
  exp_t pend[$];
  int   cyc = 0;
  int   m_cnt = 0;
  int   m_loaded = 0;
  bit   m_ovf = 0;
  bit   cur_ov = 0;
  bit   cur_hit = 0;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   hit_cnt = 0;
  bit   last_lr = 0;
  bit   last_ld_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void lookup(input int v, output bit hit, output int idx);
    hit = 0;
    idx = 0;
    for (int i = 0; i < ranges.size(); i++) begin
      if (!hit && ranges[i].s <= v && v <= ranges[i].e) begin
        hit = 1;
        idx = i;
      end
    end
  endfunction

  // One clock cycle: check handshake outputs, advance model, then check registered outputs.
  task automatic tick();
    bit   id_acc, ld_acc, exp_lr, ev, h;
    int   ix;
    exp_t e, ne;
    #1;
    id_acc = id_valid && !load_valid;
    exp_lr = (pend.size() == 0) && !id_acc;
    ld_acc = load_valid && exp_lr;
    chk("load_ready", load_ready, exp_lr);
    chk("id_ready", id_ready, !load_valid);
    last_lr = load_ready;
    last_ld_acc = ld_acc;
    if (reset) begin
      ranges.delete();
      pend.delete();
      m_cnt = 0;
      m_loaded = 0;
      m_ovf = 0;
    end else begin
      if (count_clear) m_cnt = 0;
      else if (cur_ov && cur_hit && m_cnt != CMAX) m_cnt++;
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      if (ld_acc) begin
        if (ranges.size() == DEPTH) begin
          m_ovf = 1;
          void'(ranges.pop_back());
        end
        ranges.push_front('{s: int'(start_range), e: int'(end_range)});
        if (m_loaded < DEPTH) m_loaded++;
      end
      if (id_acc) begin
        lookup(int'(id), h, ix);
        ne = '{due: cyc + DEPTH, id: int'(id), hit: h, last: id_last, idx: ix};
        pend.push_back(ne);
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    ev = 0;
    e = '{due: 0, id: 0, hit: 0, last: 0, idx: 0};
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1;
      e = pend[0];
    end
    chk("out_valid", out_valid, ev);
    chk("out_hit", out_hit, ev && e.hit);
    chk("done", done, ev && e.last);
    if (ev) begin
      chk("out_last", out_last, e.last);
      chk("out_id", out_id, e.id);
    end
`ifdef RANGE_MATCH_INDEX_EN
    chk("out_idx", out_idx, (ev && e.hit) ? e.idx : 0);
`endif
    chk("total_fresh", total_fresh, m_cnt);
    chk("loaded", loaded, m_loaded);
    chk("overflow", overflow, m_ovf);
    cur_ov = ev;
    cur_hit = ev && e.hit;
    if (done === 1'b1) done_cnt++;
    if (out_hit === 1'b1) hit_cnt++;
  endtask

  task automatic do_load(input int s, input int e);
    load_valid = 1;
    start_range = WIDTH'(s);
    end_range = WIDTH'(e);
    tick();
    load_valid = 0;
  endtask

  task automatic send_id(input int v, input bit last);
    id_valid = 1;
    id = WIDTH'(v);
    id_last = last;
    tick();
    id_valid = 0;
    id_last = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    int lows, waited, s, e;
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    tick();
    reset = 0;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_total", total_fresh, 0);
    chk("rst_loaded", loaded, 0);

    // A: no ranges loaded, id 0 must not match an empty slot
    done_cnt = 0;
    hit_cnt = 0;
    send_id(0, 0);
    send_id(5, 1);
    idle(DEPTH + 2);
    chk("A_done_pulses", done_cnt, 1);
    chk("A_hits", hit_cnt, 0);
    chk("A_total", total_fresh, 0);

    // B: four ranges, six IDs
    do_load(3, 5);
    do_load(10, 14);
    do_load(16, 20);
    do_load(12, 18);
    hit_cnt = 0;
    send_id(1, 0);
    send_id(5, 0);
    send_id(8, 0);
    send_id(11, 0);
    send_id(17, 0);
    send_id(32, 1);
    idle(DEPTH + 2);
    chk("B_hits", hit_cnt, 3);
    chk("B_total", total_fresh, 3);

    // C: overflow evicts the oldest range
    do_reset();
    do_load(3, 5);
    do_load(10, 14);
    do_load(16, 20);
    do_load(12, 18);
    chk("C_ovf_before", overflow, 0);
    do_load(100, 200);
    chk("C_ovf_after", overflow, 1);
    chk("C_loaded", loaded, DEPTH);
    hit_cnt = 0;
    send_id(4, 0);
    send_id(150, 1);
    idle(DEPTH + 2);
    chk("C_hits", hit_cnt, 1);

    // D: load requested right after an ID accept waits for the drain
    hit_cnt = 0;
    send_id(4, 0);
    load_valid = 1;
    start_range = 3;
    end_range = 5;
    lows = 0;
    waited = 0;
    last_ld_acc = 0;
    while (!last_ld_acc && waited < 20) begin
      tick();
      if (!last_lr) lows++;
      waited++;
    end
    load_valid = 0;
    chk("D_load_accepted", last_ld_acc, 1);
    chk("D_low_cycles", lows, DEPTH);
    send_id(4, 1);
    idle(DEPTH + 2);
    chk("D_hits", hit_cnt, 1);

    // E: saturation, then clear coinciding with a hit
    count_clear = 1;
    tick();
    count_clear = 0;
    send_id(4, 0);
    send_id(150, 0);
    send_id(13, 0);
    send_id(17, 0);
    send_id(4, 1);
    idle(DEPTH + 2);
    chk("E_saturated", total_fresh, 3);
    send_id(4, 1);
    idle(DEPTH - 1);
    chk("E_hit_now", out_hit, 1);
    count_clear = 1;
    tick();
    count_clear = 0;
    chk("E_clear_wins", total_fresh, 0);

    // Reset mid-stream drops in-flight tokens
    send_id(4, 0);
    send_id(13, 1);
    reset = 1;
    tick();
    reset = 0;
    idle(DEPTH + 2);
    chk("R_loaded", loaded, 0);

    // F: first-match index ordering (slot 0 = newest)
    do_load(3, 5);
    do_load(10, 14);
    do_load(16, 20);
    do_load(12, 18);
    hit_cnt = 0;
    send_id(17, 0);
    send_id(11, 0);
    send_id(5, 1);
    idle(DEPTH + 2);
    chk("F_hits", hit_cnt, 3);

    // G: randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      load_valid = ($urandom_range(0, 7) == 0);
      s = $urandom_range(0, 50);
      e = ($urandom_range(0, 4) == 0 && s > 0) ? s - 1 : s + $urandom_range(0, 10);
      start_range = WIDTH'(s);
      end_range = WIDTH'(e);
      id_valid = ($urandom_range(0, 2) != 0);
      id = WIDTH'($urandom_range(0, 63));
      id_last = ($urandom_range(0, 5) == 0);
      count_clear = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 0;
    load_valid = 0;
    id_valid = 0;
    id_last = 0;
    count_clear = 0;
    idle(DEPTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
